mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised iterative multiply/divide unit that owns the HI/LO architectural registers for the pipelined MIPS core. It takes over the HI/LO work that the execute-stage ALU currently does combinationally: a radix-2 shift-add/shift-subtract engine processes one bit per cycle. While it works it raises `busy`, and the hazard unit holds the pipeline on any HI/LO consumer until `busy` drops. It sits beside the ALU in the execute stage. Operands come from the forwarded source A and source B values.

## Interface
- `WIDTH`, default 32: operand and HI/LO width in bits; must be ≥ 4.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `start`, input, 1: accepts `op`, `srca` and `srcb` when the unit is idle.
- `op`, input, 3: `mdu_op_t` selects MULT, MULTU, DIV, DIVU, MTHI or MTLO.
- `srca`, input, WIDTH: multiplicand or dividend; MTHI/MTLO source.
- `srcb`, input, WIDTH: multiplier or divisor.
- `abort`, input, 1: cancels any running operation (execute-stage flush).
- `busy`, output, 1: an operation is in flight.
- `done`, output, 1: one-cycle pulse when HI/LO take a mult/div result.
- `hi`, output, WIDTH: HI register.
- `lo`, output, WIDTH: LO register.

## Operation
- The state machine has three states: IDLE, RUN and FIX.
- **IDLE, `start` with MULT/MULTU/DIV/DIVU, `abort` low:**
  - Latch operand magnitudes. Signed ops take absolute values; unsigned ops use operands as-is.
  - Latch the result sign flags.
  - Load count = WIDTH − 1 and go to RUN.
- **RUN, multiply:** if the multiplier LSB is 1, add the multiplicand into the upper accumulator half (WIDTH+1-bit add). Then shift the 2·WIDTH accumulator right by one.
- **RUN, divide:** shift the remainder:quotient pair left by one. Trial-subtract the divisor with a WIDTH+1-bit subtract. If the result is non-negative, keep it and set quotient LSB to 1.
- **RUN, count:** decrement each cycle. When count = 0, go to FIX.
- **FIX:**
  - Apply signs. MULT negates the 2·WIDTH product if operand signs differ. DIV negates the quotient if signs differ, and gives the remainder the dividend's sign.
  - Load HI/LO: multiply gives HI = upper half, LO = lower half; divide gives HI = remainder, LO = quotient.
  - Pulse `done` and return to IDLE.
- **Divide by zero (DIV/DIVU, `srcb` = 0):** runs the full latency, then HI = dividend (unsigned `srca`, unmodified) and LO = all ones. Nothing signals the exception.
- **MTHI/MTLO in IDLE:** at the accepting edge, load HI or LO from `srca`. `busy` stays low and `done` stays low.
- **`start` while busy:** ignored; the decode stall guarantees it does not occur.
- **`abort`:** from RUN or FIX, return to IDLE at the next edge. HI/LO are unchanged and `done` stays low. If `abort` and `start` are both high in IDLE, `start` is ignored; this includes MTHI/MTLO.
- **Boundary case:** signed WIDTH-bit minimum ÷ −1 gives LO = minimum and HI = 0; its magnitude wraps and is not trapped.

## Timing
- **Reset values:** state IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0. Reset mid-operation discards all work.
- **Mult/div:** for `start` sampled at edge E0, `busy` is 1 from E0 up to edge E0+WIDTH+1. At edge E0+WIDTH+1, HI/LO update, `busy` drops and `done` rises for exactly one cycle.
  - Total latency is WIDTH+1 cycles: WIDTH RUN + 1 FIX.
  - A new `start` may be accepted in the cycle where `done` = 1.
- **MTHI/MTLO:** HI/LO are visible one edge after `start`.
- `busy`, `done`, `hi` and `lo` are all registered outputs with no combinational input-to-output paths.

## Structure
- `mdu_pkg` holds:
  - `typedef enum logic [2:0] mdu_op_t`, with MULT = 0, MULTU = 1, DIV = 2, DIVU = 3, MTHI = 4, MTLO = 5;
  - the state enum `mdu_state_t`.
- Single sub-module `mdu_addsub #(WIDTH+1)`: a shared WIDTH+1-bit add/subtract with a sign-of-result output, used by both the multiply and divide iterations.
- The counter is `$clog2(WIDTH)` bits wide.

## Test plan
All scenarios use WIDTH = 32.
- **MULT:** MULT −3 × 5 → after 33 cycles `done` = 1, `hi` = FFFFFFFF, `lo` = FFFFFFF1; `busy` is high for exactly 33 cycles.
- **DIVU:** DIVU 100 ÷ 7 → `lo` = 0000000E, `hi` = 00000002.
- **DIV:** DIV −7 ÷ 2 → `lo` = FFFFFFFD, `hi` = FFFFFFFF.
- **Divide by zero:** DIVU 0000002A ÷ 0 → `lo` = FFFFFFFF, `hi` = 0000002A.
- **Abort:** preload HI = 1 and LO = 2 via MTHI/MTLO, start MULTU FFFFFFFF × 2, assert `abort` at cycle 10 → `busy` low the next cycle, `done` never pulses, `hi`/`lo` still 1/2. A following MULTU 3 × 4 gives `lo` = 0000000C.
- **Reset and start-while-busy:** assert `reset` mid-DIV → all outputs 0 immediately. Pulsing `start` mid-run with a different op → ignored; the original result lands on schedule.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared types for the iterative HI/LO multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_t;

    function automatic logic is_muldiv(input mdu_op_t op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed_op(input mdu_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic is_div_op(input mdu_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Execute-stage request/result bundle between the pipeline and the MDU.
interface mdu_iter_if
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    mdu_op_t          op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srca, srcb, abort,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb, abort,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter_addsub.sv
// Shared add/subtract used by both the multiply and divide iterations.
module mdu_addsub #(
    parameter int unsigned WIDTH = 33
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_y,
    output logic             o_neg
);
    always_comb begin
        o_y   = i_sub ? (i_a - i_b) : (i_a + i_b);
        o_neg = o_y[WIDTH-1];
    end
endmodule

// File: rtl/mdu_iter.sv
// Radix-2 iterative multiply/divide unit owning the HI/LO registers.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mdu_iter_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    mdu_state_t         r_state;
    mdu_state_t         w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opd;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dbz;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_load;
    logic               w_commit;
    logic               w_signed;
    logic               w_div;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_as_a;
    logic [WIDTH:0]     w_as_b;
    logic [WIDTH:0]     w_sum;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_accept     = (r_state == ST_IDLE) && bus.start && !bus.abort;
        w_load       = w_accept && is_muldiv(bus.op);
        case (r_state)
            ST_IDLE: if (w_load) w_state_next = ST_RUN;
            ST_RUN: begin
                if (bus.abort)        w_state_next = ST_IDLE;
                else if (r_cnt == '0) w_state_next = ST_FIX;
            end
            ST_FIX: begin
                w_state_next = ST_IDLE;
                w_commit     = !bus.abort;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_signed = is_signed_op(bus.op);
        w_div    = is_div_op(bus.op);
        w_a_mag  = (w_signed && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
        w_b_mag  = (w_signed && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;
    end

    // Divide feeds the shifted remainder (with its carried-out bit); multiply feeds the upper half.
    always_comb begin
        if (r_is_div) begin
            w_as_a = r_acc[2*WIDTH-1:WIDTH-1];
            w_as_b = {1'b0, r_opd};
        end else begin
            w_as_a = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
            w_as_b = r_acc[0] ? {1'b0, r_opd} : '0;
        end
    end

    mdu_addsub #(.WIDTH(WIDTH + 1)) u_addsub (
        .i_a   (w_as_a),
        .i_b   (w_as_b),
        .i_sub (r_is_div),
        .o_y   (w_sum),
        .o_neg (w_neg)
    );

    always_comb begin
        if (r_is_div) begin
            w_acc_step = w_neg ? {r_acc[2*WIDTH-2:0], 1'b0}
                               : {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_step = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    // A zero divisor leaves the dividend magnitude as remainder, so re-signing restores srca.
    always_comb begin
        w_prod   = r_neg_res ? -r_acc : r_acc;
        w_quo    = r_dbz ? '1 : (r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
        w_rem    = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_hi_res = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        w_lo_res = r_is_div ? w_quo : w_prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opd     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= w_commit;
            if (w_load) begin
                r_acc     <= {{WIDTH{1'b0}}, (w_div ? w_a_mag : w_b_mag)};
                r_opd     <= w_div ? w_b_mag : w_a_mag;
                r_is_div  <= w_div;
                r_neg_res <= w_signed && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
                r_neg_rem <= w_signed && bus.srca[WIDTH-1];
                r_dbz     <= w_div && (bus.srcb == '0);
                r_cnt     <= CW'(WIDTH - 1);
            end else if (r_state == ST_RUN) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_hi <= w_hi_res;
                r_lo <= w_lo_res;
            end
            if (w_accept && (bus.op == MTHI)) r_hi <= bus.srca;
            if (w_accept && (bus.op == MTLO)) r_lo <= bus.srca;
        end
    end

    assign bus.busy = (r_state != ST_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter at WIDTH = 32.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    mdu_iter_if #(.WIDTH(32)) bus ();

    mdu_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
    endtask

    task automatic muldiv(input string tag, input mdu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        issue(op, a, b);
        wait_idle(cyc);
        check({tag, ".busy_cycles"}, 64'(cyc), 64'd33);
        check({tag, ".done"}, 64'(bus.done), 64'd1);
        check({tag, ".hi"}, 64'(bus.hi), 64'(ehi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(elo));
        tick();
        check({tag, ".done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int  cyc;
        bit  saw_done;
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = MULT;
        bus.srca  = '0;
        bus.srcb  = '0;
        bus.abort = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.hi", 64'(bus.hi), 64'd0);
        check("reset.lo", 64'(bus.lo), 64'd0);

        muldiv("mult_m3x5", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        muldiv("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        muldiv("divu_100_7", DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
        muldiv("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        muldiv("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        muldiv("divu_by0", DIVU, 32'h0000_002A, 32'd0, 32'h0000_002A, 32'hFFFF_FFFF);
        muldiv("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // MTHI/MTLO preload, then abort a running MULTU
        issue(MTHI, 32'd1, 32'd0);
        check("mthi.hi", 64'(bus.hi), 64'd1);
        check("mthi.busy", 64'(bus.busy), 64'd0);
        check("mthi.done", 64'(bus.done), 64'd0);
        issue(MTLO, 32'd2, 32'd0);
        check("mtlo.lo", 64'(bus.lo), 64'd2);
        bus.abort = 1'b1;
        issue(MTHI, 32'hDEAD_BEEF, 32'd0);
        bus.abort = 1'b0;
        check("abort_blocks_mthi.hi", 64'(bus.hi), 64'd1);

        issue(MULTU, 32'hFFFF_FFFF, 32'd2);
        check("abort.busy_started", 64'(bus.busy), 64'd1);
        repeat (9) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort.busy_low", 64'(bus.busy), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            tick();
        end
        check("abort.no_done", 64'(saw_done), 64'd0);
        check("abort.hi", 64'(bus.hi), 64'd1);
        check("abort.lo", 64'(bus.lo), 64'd2);
        muldiv("multu_3x4", MULTU, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C);

        // Asynchronous reset mid-DIV
        issue(DIV, 32'd1000, 32'd3);
        repeat (10) tick();
        #2;
        reset = 1'b1;
        #1;
        check("midreset.busy", 64'(bus.busy), 64'd0);
        check("midreset.done", 64'(bus.done), 64'd0);
        check("midreset.hi", 64'(bus.hi), 64'd0);
        check("midreset.lo", 64'(bus.lo), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // start pulsed mid-run with a different op must be ignored
        issue(DIVU, 32'd100, 32'd7);
        repeat (5) tick();
        issue(MULTU, 32'd3, 32'd4);
        wait_idle(cyc);
        check("startbusy.busy_cycles", 64'(cyc + 6), 64'd33);
        check("startbusy.done", 64'(bus.done), 64'd1);
        check("startbusy.hi", 64'(bus.hi), 64'd2);
        check("startbusy.lo", 64'(bus.lo), 64'hE);
        tick();
        check("startbusy.idle_after", 64'(bus.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
